// File: rtl/hier_icache_flush_seq.sv
// Hierarchical instruction-cache flush sequencer: flushes all L2 banks, then the selected L1 caches.
// Optional per-phase watchdog enabled by defining HIER_ICACHE_FLUSH_SEQ_TIMEOUT_EN.
module hier_icache_flush_seq #(
    parameter int NB_CACHE_BANKS = 4,
    parameter int NB_CORES       = 9,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_sel_i,
    input  logic [31:0]               cmd_addr_i,
    input  logic [NB_CORES-1:0]       cmd_core_mask_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [NB_CACHE_BANKS-1:0] l2_flush_req_o,
    output logic [NB_CACHE_BANKS-1:0] l2_sel_flush_req_o,
    input  logic [NB_CACHE_BANKS-1:0] l2_flush_ack_i,
    input  logic [NB_CACHE_BANKS-1:0] l2_sel_flush_ack_i,
    output logic [NB_CORES-1:0]       l1_flush_req_o,
    output logic [NB_CORES-1:0]       l1_sel_flush_req_o,
    input  logic [NB_CORES-1:0]       l1_flush_ack_i,
    input  logic [NB_CORES-1:0]       l1_sel_flush_ack_i,
    output logic [31:0]               sel_flush_addr_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        L2_PH = 2'd1,
        L1_PH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    state_r, state_s;
    logic                      sel_r, sel_s;
    logic [31:0]               addr_r, addr_s;
    logic [NB_CORES-1:0]       mask_r, mask_s;
    logic [NB_CACHE_BANKS-1:0] l2_pend_r, l2_pend_s;
    logic [NB_CORES-1:0]       l1_pend_r, l1_pend_s;
    logic                      err_r, err_s;
    logic                      timeout_s;
    logic [NB_CACHE_BANKS-1:0] l2_ack_s;
    logic [NB_CORES-1:0]       l1_ack_s;

    // Only the bus matching the latched command type can retire pending targets.
    assign l2_ack_s = sel_r ? l2_sel_flush_ack_i : l2_flush_ack_i;
    assign l1_ack_s = sel_r ? l1_sel_flush_ack_i : l1_flush_ack_i;

`ifdef HIER_ICACHE_FLUSH_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_r;

    // Phase watchdog: restarts on every state change, idles outside the two phases.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else if ((state_s != state_r) || (state_r == IDLE) || (state_r == DONE)) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    // Firing one count early lands DONE exactly TIMEOUT_CYCLES after phase entry.
    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_unused
    end
`endif

    // Sequencer state and command/pending registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            sel_r     <= 1'b0;
            addr_r    <= 32'h0;
            mask_r    <= '0;
            l2_pend_r <= '0;
            l1_pend_r <= '0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            sel_r     <= sel_s;
            addr_r    <= addr_s;
            mask_r    <= mask_s;
            l2_pend_r <= l2_pend_s;
            l1_pend_r <= l1_pend_s;
            err_r     <= err_s;
        end
    end

    // Next-state logic; phase exit looks at the post-ack pending set so same-cycle acks advance at once.
    always_comb begin
        state_s   = state_r;
        sel_s     = sel_r;
        addr_s    = addr_r;
        mask_s    = mask_r;
        l2_pend_s = l2_pend_r;
        l1_pend_s = l1_pend_r;
        err_s     = err_r;
        case (state_r)
            IDLE: begin
                err_s = 1'b0;
                if (cmd_valid_i) begin
                    sel_s     = cmd_sel_i;
                    addr_s    = cmd_addr_i;
                    mask_s    = cmd_core_mask_i;
                    l2_pend_s = '1;
                    state_s   = L2_PH;
                end else begin
                    state_s = IDLE;
                end
            end
            L2_PH: begin
                l2_pend_s = l2_pend_r & ~l2_ack_s;
                if (l2_pend_s == '0) begin
                    l1_pend_s = mask_r;
                    state_s   = (mask_r == '0) ? DONE : L1_PH;
                end else if (timeout_s) begin
                    l2_pend_s = '0;
                    err_s     = 1'b1;
                    state_s   = DONE;
                end else begin
                    state_s = L2_PH;
                end
            end
            L1_PH: begin
                l1_pend_s = l1_pend_r & ~l1_ack_s;
                if (l1_pend_s == '0) begin
                    state_s = DONE;
                end else if (timeout_s) begin
                    l1_pend_s = '0;
                    err_s     = 1'b1;
                    state_s   = DONE;
                end else begin
                    state_s = L1_PH;
                end
            end
            DONE: begin
                err_s   = 1'b0;
                addr_s  = 32'h0;
                state_s = IDLE;
            end
            default: begin
                l2_pend_s = '0;
                l1_pend_s = '0;
                err_s     = 1'b0;
                state_s   = IDLE;
            end
        endcase
    end

    assign cmd_ready_o        = (state_r == IDLE);
    assign busy_o             = (state_r != IDLE);
    assign done_o             = (state_r == DONE);
    assign err_o              = err_r;
    assign sel_flush_addr_o   = addr_r;
    assign l2_flush_req_o     = sel_r ? '0 : l2_pend_r;
    assign l2_sel_flush_req_o = sel_r ? l2_pend_r : '0;
    assign l1_flush_req_o     = sel_r ? '0 : l1_pend_r;
    assign l1_sel_flush_req_o = sel_r ? l1_pend_r : '0;

endmodule

// File: tb/tb_hier_icache_flush_seq.sv
// Directed bench for hier_icache_flush_seq; completion events are checked against a scoreboard queue.
module tb_hier_icache_flush_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_sel = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [8:0]  cmd_mask = 9'h0;
    logic        busy, done, err;
    logic [3:0]  l2_flush_req, l2_sel_flush_req, l2_flush_ack, l2_sel_flush_ack;
    logic [8:0]  l1_flush_req, l1_sel_flush_req, l1_flush_ack, l1_sel_flush_ack;
    logic [31:0] sel_addr;

    logic [3:0]  l2_en = 4'h0, l2_spur_f = 4'h0, l2_spur_s = 4'h0;
    logic [8:0]  l1_en = 9'h0, l1_spur_f = 9'h0, l1_spur_s = 9'h0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        int   cyc;
        logic err;
    } exp_t;
    exp_t sb[$];

    // Responder: enabled targets ack in the same cycle their request is seen.
    assign l2_flush_ack     = (l2_flush_req & l2_en) | l2_spur_f;
    assign l2_sel_flush_ack = (l2_sel_flush_req & l2_en) | l2_spur_s;
    assign l1_flush_ack     = (l1_flush_req & l1_en) | l1_spur_f;
    assign l1_sel_flush_ack = (l1_sel_flush_req & l1_en) | l1_spur_s;

    hier_icache_flush_seq #(
        .NB_CACHE_BANKS(4),
        .NB_CORES      (9),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .cmd_valid_i       (cmd_valid),
        .cmd_ready_o       (cmd_ready),
        .cmd_sel_i         (cmd_sel),
        .cmd_addr_i        (cmd_addr),
        .cmd_core_mask_i   (cmd_mask),
        .busy_o            (busy),
        .done_o            (done),
        .err_o             (err),
        .l2_flush_req_o    (l2_flush_req),
        .l2_sel_flush_req_o(l2_sel_flush_req),
        .l2_flush_ack_i    (l2_flush_ack),
        .l2_sel_flush_ack_i(l2_sel_flush_ack),
        .l1_flush_req_o    (l1_flush_req),
        .l1_sel_flush_req_o(l1_sel_flush_req),
        .l1_flush_ack_i    (l1_flush_ack),
        .l1_sel_flush_ack_i(l1_sel_flush_ack),
        .sel_flush_addr_o  (sel_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Wait for the sampling point (negedge) of cycle c.
    task automatic at_cycle(input int c);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (cyc < c && k < 1000);
        check("cycle_reached", 64'(cyc), 64'(c));
    endtask

    // Wait until just after the posedge that starts cycle c.
    task automatic drive_at(input int c);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (cyc < c && k < 1000);
    endtask

    task automatic send(input logic sel, input logic [31:0] addr, input logic [8:0] mask,
                        input logic hold, output int t);
        int k;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_addr  = addr;
        cmd_mask  = mask;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cmd_ready && k < 100);
        check("accept", 64'(cmd_ready), 64'd1);
        t = cyc;
        @(posedge clk);
        #1;
        cmd_valid = hold;
    endtask

    // Completion monitor plus bus exclusivity on every cycle out of reset.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("l2_bus_excl", 64'((|l2_flush_req) & (|l2_sel_flush_req)), 64'd0);
            check("l1_bus_excl", 64'((|l1_flush_req) & (|l1_sel_flush_req)), 64'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                    check("done_err", 64'(err), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        int t;
        logic [3:0] ex;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_reqs", 64'({l2_flush_req, l2_sel_flush_req, l1_flush_req, l1_sel_flush_req}), 64'd0);
        check("rst_addr", 64'(sel_addr), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full flush, all acks immediate: minimum latency
        l2_en = 4'hF;
        l1_en = 9'h1FF;
        send(1'b0, 32'h0, 9'h1FF, 1'b0, t);
        sb.push_back('{t + 3, 1'b0});
        at_cycle(t + 1);
        check("full_l2_req", 64'(l2_flush_req), 64'hF);
        check("full_l2_sel", 64'(l2_sel_flush_req), 64'h0);
        check("full_l1_idle", 64'(l1_flush_req | l1_sel_flush_req), 64'h0);
        check("full_busy", 64'(busy), 64'd1);
        check("full_ready", 64'(cmd_ready), 64'd0);
        at_cycle(t + 2);
        check("full_l1_req", 64'(l1_flush_req), 64'h1FF);
        check("full_l2_off", 64'(l2_flush_req), 64'h0);
        at_cycle(t + 4);
        check("full_ready_back", 64'(cmd_ready), 64'd1);
        check("full_busy_off", 64'(busy), 64'd0);

        // Selective flush with staggered bank acks
        l2_en = 4'h0;
        send(1'b1, 32'h1C00_8040, 9'h005, 1'b0, t);
        sb.push_back('{t + 7, 1'b0});
        at_cycle(t + 1);
        check("sel_l2_req", 64'(l2_sel_flush_req), 64'hF);
        check("sel_l2_flush_quiet", 64'(l2_flush_req), 64'h0);
        check("sel_addr", 64'(sel_addr), 64'h1C00_8040);
        for (int i = 0; i < 4; i++) begin
            drive_at(t + 2 + i);
            l2_en = 4'h1 << i;
            at_cycle(t + 2 + i);
            ex = 4'hF << i;
            check("sel_l2_pending", 64'(l2_sel_flush_req), 64'(ex));
            check("sel_l1_wait", 64'(l1_flush_req | l1_sel_flush_req), 64'h0);
        end
        at_cycle(t + 6);
        check("sel_l1_req", 64'(l1_sel_flush_req), 64'h005);
        check("sel_l1_flush_quiet", 64'(l1_flush_req), 64'h0);
        check("sel_l2_done", 64'(l2_flush_req | l2_sel_flush_req), 64'h0);
        check("sel_addr_l1", 64'(sel_addr), 64'h1C00_8040);
        at_cycle(t + 8);
        check("sel_addr_clr", 64'(sel_addr), 64'h0);
        check("sel_ready_back", 64'(cmd_ready), 64'd1);

        // Empty core mask skips the L1 phase
        l2_en = 4'h0;
        send(1'b0, 32'h0, 9'h000, 1'b0, t);
        sb.push_back('{t + 3, 1'b0});
        at_cycle(t + 1);
        check("m0_l2_req", 64'(l2_flush_req), 64'hF);
        drive_at(t + 2);
        l2_en = 4'hF;
        at_cycle(t + 2);
        check("m0_l1_quiet", 64'(l1_flush_req | l1_sel_flush_req), 64'h0);
        at_cycle(t + 3);
        check("m0_l1_quiet_done", 64'(l1_flush_req | l1_sel_flush_req), 64'h0);
        at_cycle(t + 4);
        check("m0_ready_back", 64'(cmd_ready), 64'd1);

        // Command held valid while busy; spurious acks on idle targets and unused bus
        l2_en = 4'h0;
        l1_en = 9'h0;
        l2_spur_s = 4'hF;
        l1_spur_f = 9'h1FC;
        send(1'b0, 32'h0, 9'h003, 1'b1, t);
        sb.push_back('{t + 6, 1'b0});
        sb.push_back('{t + 10, 1'b0});
        at_cycle(t + 1);
        check("hold_ready_busy", 64'(cmd_ready), 64'd0);
        check("hold_l2_req", 64'(l2_flush_req), 64'hF);
        at_cycle(t + 2);
        check("hold_spur_l2", 64'(l2_flush_req), 64'hF);
        drive_at(t + 3);
        l2_spur_s = 4'h0;
        l2_en = 4'hF;
        at_cycle(t + 4);
        check("hold_spur_l1", 64'(l1_flush_req), 64'h003);
        check("hold_ready_l1", 64'(cmd_ready), 64'd0);
        drive_at(t + 5);
        l1_en = 9'h1FF;
        at_cycle(t + 6);
        check("hold_ready_done", 64'(cmd_ready), 64'd0);
        at_cycle(t + 7);
        check("hold_ready_idle", 64'(cmd_ready), 64'd1);
        drive_at(t + 8);
        cmd_valid = 1'b0;
        l1_spur_f = 9'h0;
        at_cycle(t + 8);
        check("hold_second_busy", 64'(busy), 64'd1);
        check("hold_second_l2", 64'(l2_flush_req), 64'hF);
        at_cycle(t + 11);
        check("hold_second_ready", 64'(cmd_ready), 64'd1);

        // Reset during the L1 phase
        l2_en = 4'hF;
        l1_en = 9'h0;
        send(1'b0, 32'h0, 9'h1FF, 1'b0, t);
        at_cycle(t + 2);
        check("rstmid_l1_req", 64'(l1_flush_req), 64'h1FF);
        drive_at(t + 3);
        rst = 1'b1;
        at_cycle(t + 4);
        check("rstmid_reqs", 64'({l2_flush_req, l2_sel_flush_req, l1_flush_req, l1_sel_flush_req}), 64'd0);
        check("rstmid_done", 64'(done), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_ready", 64'(cmd_ready), 64'd1);
        drive_at(t + 5);
        rst = 1'b0;
        l1_en = 9'h1FF;
        at_cycle(t + 8);
        check("rstmid_ready_after", 64'(cmd_ready), 64'd1);
        check("rstmid_busy_after", 64'(busy), 64'd0);

`ifdef HIER_ICACHE_FLUSH_SEQ_TIMEOUT_EN
        // Bank 2 never acks: watchdog ends the L2 phase with an error
        l2_en = 4'b1011;
        send(1'b0, 32'h0, 9'h1FF, 1'b0, t);
        sb.push_back('{t + 17, 1'b1});
        at_cycle(t + 16);
        check("to_l2_stuck", 64'(l2_flush_req), 64'h4);
        at_cycle(t + 17);
        check("to_reqs_dropped", 64'({l2_flush_req, l1_flush_req}), 64'd0);
        at_cycle(t + 18);
        check("to_ready_back", 64'(cmd_ready), 64'd1);
        check("to_err_clr", 64'(err), 64'd0);
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
